// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its pickers.
// Widths are derived here so the read-side scheduler can reuse them unchanged.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } arb_state_e;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request at or
// after rr_ptr, wrapping modulo NUM_REQ (works for non-power-of-two counts).
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               found,
    output logic [PTR_W-1:0]   index
);

    always_comb begin
        logic [PTR_W:0] pos;
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit keeps rr_ptr + i from overflowing before the wrap.
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                found = 1'b1;
                index = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the FIFO write port among NUM_REQ
// producers; write enable and data are driven combinationally from the owner.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_last,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_fifo_wren,
    output logic [DATA_W-1:0]           o_fifo_wrdata,
    input  logic                        i_fifo_full,
    input  logic                        i_fifo_alm_full,
    output logic                        o_busy,
    output logic [$clog2(NUM_REQ)-1:0]  o_owner
);

    localparam int PTR_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    arb_state_e        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  beat_cnt;

    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;
    logic              busy;
    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              xfer;
    logic              burst_end;
    logic              grant;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (i_req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign busy      = (state == BURST);
    assign own_valid = i_req_valid[owner];
    assign own_last  = i_req_last[owner];
    assign own_data  = i_req_data[owner*DATA_W +: DATA_W];

    // Full is checked here rather than trusting the FIFO to drop the write.
    assign xfer      = busy && own_valid && !i_fifo_full;
    assign burst_end = xfer && (own_last || (beat_cnt == LAST_BEAT));
    assign grant     = (state == IDLE) && pick_found && !i_fifo_alm_full;

    always_comb begin
        o_req_ready = '0;
        if (busy && !i_fifo_full) begin
            o_req_ready[owner] = 1'b1;
        end
    end

    assign o_fifo_wren   = xfer;
    assign o_fifo_wrdata = busy ? own_data : '0;
    assign o_busy        = busy;
    assign o_owner       = owner;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    // An owner that stops sending keeps the grant until last or the cap.
                    if (burst_end) begin
                        state  <= IDLE;
                        rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a per-cycle vector table for the basic handshake,
// then queued producers with an expected-write scoreboard for multi-cycle cases.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 128;
    localparam int MAX_BURST = 8;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] last;
        logic               full;
        logic               alm;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_wren;
        logic               exp_busy;
        logic [1:0]         exp_owner;
    } vec_t;

    typedef struct {
        logic [1:0]        owner;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic [NUM_REQ-1:0]          drv_valid;
    logic [NUM_REQ-1:0]          drv_last;
    logic [NUM_REQ*DATA_W-1:0]   drv_data;
    logic                        drv_full;
    logic                        drv_alm;
    logic [NUM_REQ-1:0]          ready;
    logic                        wren;
    logic [DATA_W-1:0]           wrdata;
    logic                        busy;
    logic [1:0]                  owner;

    int    n_checks = 0;
    int    n_errors = 0;
    vec_t  vecs[$];
    beat_t exp_q[$];
    int    grant_log[$];
    logic [DATA_W:0] prod_q[NUM_REQ][$];
    int    acc_cnt[NUM_REQ];
    logic  prev_busy;
    logic  snap_wren;
    logic  snap_busy;
    logic [NUM_REQ-1:0] snap_ready;
    logic [1:0] snap_owner;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_req_valid     (drv_valid),
        .i_req_data      (drv_data),
        .i_req_last      (drv_last),
        .o_req_ready     (ready),
        .o_fifo_wren     (wren),
        .o_fifo_wrdata   (wrdata),
        .i_fifo_full     (drv_full),
        .i_fifo_alm_full (drv_alm),
        .o_busy          (busy),
        .o_owner         (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] make_pdata(input int k, input int seq);
        return {8'(k), 24'(seq), 32'(seq * 3 + k), 32'(~seq), 32'(k * 1000 + seq)};
    endfunction

    function automatic logic [DATA_W-1:0] make_tdata(input int row, input int k);
        return {8'hEE, 8'(row), 8'(k), 104'(row * 16 + k + 1)};
    endfunction

    task automatic add_vec(input logic [3:0] v, input logic [3:0] l, input logic f,
                           input logic a, input logic [3:0] er, input logic ew,
                           input logic eb, input logic [1:0] eo);
        vecs.push_back('{v, l, f, a, er, ew, eb, eo});
    endtask

    task automatic load_beats(input int k, input int seq0, input int n, input int last_every);
        for (int i = 0; i < n; i++) begin
            logic lst;
            lst = (last_every > 0) && (((i + 1) % last_every) == 0);
            prod_q[k].push_back({lst, make_pdata(k, seq0 + i)});
        end
    endtask

    task automatic expect_beats(input int k, input int seq0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{2'(k), make_pdata(k, seq0 + i)});
        end
    endtask

    task automatic drive_producers();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (prod_q[k].size() > 0) begin
                drv_valid[k] = 1'b1;
                drv_last[k]  = prod_q[k][0][DATA_W];
                drv_data[k*DATA_W +: DATA_W] = prod_q[k][0][DATA_W-1:0];
            end else begin
                drv_valid[k] = 1'b0;
                drv_last[k]  = 1'b0;
                drv_data[k*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    // One clock with queued producers: sample and score at negedge, retire accepted beats after posedge.
    task automatic apply_stimulus();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] onehot;
        beat_t b;
        drive_producers();
        @(negedge clk);
        snap_ready = ready;
        snap_wren  = wren;
        snap_busy  = busy;
        snap_owner = owner;
        onehot = NUM_REQ'(1) << owner;
        check_output("ready_non_owner", DATA_W'(ready & ~onehot), '0);
        check_output("wren_while_full", DATA_W'(wren & drv_full), '0);
        check_output("wren_handshake", DATA_W'(wren), DATA_W'(|(ready & drv_valid)));
        if (wren) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL sb_unexpected: got owner %0d data %0h expected no write", owner, wrdata);
            end else begin
                b = exp_q.pop_front();
                check_output("sb_owner", DATA_W'(owner), DATA_W'(b.owner));
                check_output("sb_data", wrdata, b.data);
            end
        end
        if (busy && !prev_busy) grant_log.push_back(int'(owner));
        prev_busy = busy;
        acc = ready & drv_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acc[k]) begin
                void'(prod_q[k].pop_front());
                acc_cnt[k]++;
            end
        end
    endtask

    initial begin
        int exp_g_b[5];
        int exp_g_c[3];
        int guard;
        logic [14:0] wren_log;
        logic [14:0] exp_pat;

        exp_g_b = '{0, 1, 2, 3, 0};
        exp_g_c = '{0, 2, 0};
        rstn = 1'b0;
        drv_valid = '0; drv_last = '0; drv_data = '0;
        drv_full = 1'b0; drv_alm = 1'b0;
        prev_busy = 1'b0;
        snap_busy = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) acc_cnt[k] = 0;

        //      valid    last     f     a     ready    wren  busy  owner
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        add_vec(4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        add_vec(4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
        add_vec(4'b1111, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2);
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
        add_vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3);
        add_vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0);
        add_vec(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0);
        add_vec(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0);
        add_vec(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
        add_vec(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0);
        add_vec(4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int r = 0; r < vecs.size(); r++) begin
            logic [DATA_W-1:0] exp_data;
            drv_valid = vecs[r].valid;
            drv_last  = vecs[r].last;
            drv_full  = vecs[r].full;
            drv_alm   = vecs[r].alm;
            for (int k = 0; k < NUM_REQ; k++) drv_data[k*DATA_W +: DATA_W] = make_tdata(r, k);
            exp_data = vecs[r].exp_busy ? make_tdata(r, int'(vecs[r].exp_owner)) : '0;
            @(negedge clk);
            check_output($sformatf("vec%0d_ready", r), DATA_W'(ready), DATA_W'(vecs[r].exp_ready));
            check_output($sformatf("vec%0d_wren", r), DATA_W'(wren), DATA_W'(vecs[r].exp_wren));
            check_output($sformatf("vec%0d_busy", r), DATA_W'(busy), DATA_W'(vecs[r].exp_busy));
            check_output($sformatf("vec%0d_owner", r), DATA_W'(owner), DATA_W'(vecs[r].exp_owner));
            check_output($sformatf("vec%0d_wrdata", r), wrdata, exp_data);
            @(posedge clk);
            #1;
        end
        drv_valid = '0; drv_last = '0; drv_data = '0;
        drv_full = 1'b0; drv_alm = 1'b0;

        // Reset in the middle of a 5-beat burst from requester 2.
        $display("[TB] reset mid-burst");
        load_beats(2, 500, 5, 5);
        expect_beats(2, 500, 2);
        guard = 0;
        while (acc_cnt[2] < 2 && guard < 20) begin
            apply_stimulus();
            guard++;
        end
        check_output("rst_reach_beat2", DATA_W'(acc_cnt[2]), DATA_W'(2));
        for (int k = 0; k < NUM_REQ; k++) prod_q[k].delete();
        rstn = 1'b0;
        drive_producers();
        @(posedge clk);
        #1;
        drv_valid = 4'b0100;
        @(negedge clk);
        check_output("rst_ready", DATA_W'(ready), '0);
        check_output("rst_wren", DATA_W'(wren), '0);
        check_output("rst_busy", DATA_W'(busy), '0);
        check_output("rst_owner", DATA_W'(owner), '0);
        check_output("rst_wrdata", wrdata, '0);
        check_output("rst_sb_empty", DATA_W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        prev_busy = 1'b0;
        grant_log.delete();

        // All requesters valid with 2-beat bursts; restart must begin at requester 0.
        $display("[TB] round-robin rotation");
        load_beats(0, 0, 4, 2);
        for (int k = 1; k < NUM_REQ; k++) load_beats(k, 0, 2, 2);
        expect_beats(0, 0, 2);
        expect_beats(1, 0, 2);
        expect_beats(2, 0, 2);
        expect_beats(3, 0, 2);
        expect_beats(0, 2, 2);
        for (int c = 0; c < 15; c++) begin
            apply_stimulus();
            wren_log[c] = snap_wren;
            exp_pat[c]  = ((c % 3) != 0);
        end
        check_output("rr_wren_pattern", DATA_W'(wren_log), DATA_W'(exp_pat));
        check_output("rr_sb_empty", DATA_W'(exp_q.size()), '0);
        check_output("rr_grant_count", DATA_W'(grant_log.size()), DATA_W'(5));
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check_output($sformatf("rr_grant%0d", i), DATA_W'(grant_log[i]), DATA_W'(exp_g_b[i]));
        end

        // Burst cap with a 3-cycle full stall inside requester 0's first burst.
        $display("[TB] burst cap and full stall");
        exp_q.delete();
        grant_log.delete();
        for (int k = 0; k < NUM_REQ; k++) acc_cnt[k] = 0;
        expect_beats(0, 100, 8);
        expect_beats(2, 200, 3);
        expect_beats(0, 108, 8);
        load_beats(0, 100, 16, 0);
        guard = 0;
        snap_busy = 1'b0;
        while (!snap_busy && guard < 5) begin
            apply_stimulus();
            guard++;
        end
        check_output("cap_first_grant", DATA_W'(snap_busy), DATA_W'(1));
        load_beats(2, 200, 3, 3);
        guard = 0;
        while (acc_cnt[0] < 3 && guard < 20) begin
            apply_stimulus();
            guard++;
        end
        check_output("cap_pre_stall_beats", DATA_W'(acc_cnt[0]), DATA_W'(3));
        drv_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            apply_stimulus();
            check_output($sformatf("stall%0d_ready", s), DATA_W'(snap_ready), '0);
            check_output($sformatf("stall%0d_wren", s), DATA_W'(snap_wren), '0);
            check_output($sformatf("stall%0d_busy", s), DATA_W'(snap_busy), DATA_W'(1));
        end
        drv_full = 1'b0;
        apply_stimulus();
        check_output("stall_resume_wren", DATA_W'(snap_wren), DATA_W'(1));
        check_output("stall_resume_owner", DATA_W'(snap_owner), '0);
        guard = 0;
        while ((exp_q.size() != 0 || snap_busy) && guard < 200) begin
            apply_stimulus();
            guard++;
        end
        check_output("cap_drain_bound", DATA_W'(guard < 200), DATA_W'(1));
        check_output("cap_sb_empty", DATA_W'(exp_q.size()), '0);
        check_output("cap_req0_beats", DATA_W'(acc_cnt[0]), DATA_W'(16));
        check_output("cap_req2_beats", DATA_W'(acc_cnt[2]), DATA_W'(3));
        check_output("cap_grant_count", DATA_W'(grant_log.size()), DATA_W'(3));
        for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
            check_output($sformatf("cap_grant%0d", i), DATA_W'(grant_log[i]), DATA_W'(exp_g_c[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
